// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: phase synchronisers, glitch filter, x1/x2/x4 up/down position counter.
// Optional index support (Z input, idx strobe) is compiled in when QUAD_INDEX_EN is defined.
//
// state | meaning
// INIT  | waiting for the first accepted level after reset to seed prev_ph
// TRACK | decoding each accepted level against prev_ph
module quad_decoder #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    A,
    input  logic                    B,
`ifdef QUAD_INDEX_EN
    input  logic                    Z,
    output logic                    idx,
`endif
    input  logic [1:0]              mode,
    input  logic                    clr,
    output logic signed [CNT_W-1:0] count,
    output logic                    pulse,
    output logic                    dir,
    output logic                    err,
    output logic                    ovf
);

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic [3:0]              TMR_LOAD = 4'(FILT_LEN - 1);
    localparam logic signed [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

    logic [1:0] a_sync, b_sync;
    logic [1:0] ab_s;
    logic [1:0] cand, filt, prev_ph;
    logic       filt_vld;
    logic [3:0] tmr;
    logic       acc;
    state_t     state_q, state_d;
    logic       load_prev, illegal, counted, fwd;
    logic [1:0] diff, pos_prev, pos_new;
    logic       idx_clr;

    assign ab_s = {a_sync[1], b_sync[1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[0], A};
            b_sync <= {b_sync[0], B};
        end
    end

    // Down-counter runs while a candidate differs from the accepted level; terminal count accepts it.
    // Until the first acceptance there is no valid level, so any stable value qualifies.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cand     <= '0;
            filt     <= '0;
            filt_vld <= 1'b0;
            tmr      <= '0;
            acc      <= 1'b0;
        end else begin
            acc <= 1'b0;
            if (filt_vld && ab_s == filt) begin
                tmr <= '0;
            end else if (tmr == 4'd0 || ab_s != cand) begin
                cand <= ab_s;
                if (FILT_LEN == 1) begin
                    filt     <= ab_s;
                    filt_vld <= 1'b1;
                    acc      <= 1'b1;
                end else begin
                    tmr <= TMR_LOAD;
                end
            end else if (tmr == 4'd1) begin
                filt     <= cand;
                filt_vld <= 1'b1;
                acc      <= 1'b1;
                tmr      <= '0;
            end else begin
                tmr <= tmr - 4'd1;
            end
        end
    end

`ifdef QUAD_INDEX_EN
    logic [2:0] z_sync;

    assign idx_clr = z_sync[1] && !z_sync[2] && filt_vld && (filt == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            z_sync <= '0;
            idx    <= 1'b0;
        end else begin
            z_sync <= {z_sync[1:0], Z};
            idx    <= idx_clr && !clr;
        end
    end
`else
    assign idx_clr = 1'b0;
`endif

    // Position within the forward cycle 00->10->11->01 is {B, A^B}, so forward is +1 mod 4.
    always_comb begin
        state_d   = state_q;
        load_prev = 1'b0;
        illegal   = 1'b0;
        counted   = 1'b0;
        fwd       = 1'b0;
        diff      = prev_ph ^ filt;
        pos_prev  = {prev_ph[0], ^prev_ph};
        pos_new   = {filt[0], ^filt};
        if (acc) begin
            load_prev = 1'b1;
            case (state_q)
                INIT:  state_d = TRACK;
                TRACK: begin
                    if (diff == 2'b11) begin
                        illegal = 1'b1;
                    end else if (diff != 2'b00) begin
                        fwd = (pos_new == pos_prev + 2'd1);
                        casez (mode)
                            2'b1?:   counted = 1'b1;
                            2'b01:   counted = diff[1];
                            default: counted = (prev_ph == 2'b00 && filt == 2'b10) ||
                                               (prev_ph == 2'b10 && filt == 2'b00);
                        endcase
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
            prev_ph <= '0;
            count   <= '0;
            pulse   <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse   <= counted;
            ovf     <= 1'b0;
            if (load_prev) prev_ph <= filt;
            if (counted)   dir     <= fwd;
            if (clr || idx_clr) begin
                count <= '0;
            end else if (counted) begin
                count <= fwd ? count + CNT_ONE : count - CNT_ONE;
                ovf   <= fwd ? (count == CNT_MAX) : (count == CNT_MIN);
            end
            if (illegal)  err <= 1'b1;
            else if (clr) err <= 1'b0;
        end
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter CNT_W, default 16, position counter width, legal range 2..32.
REQ-002 Parameter FILT_LEN, default 3, consecutive identical samples needed to accept a new A/B level, legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 A, B  input  1 each  raw asynchronous encoder phases.
REQ-006 mode  input  2  00 = x1, 01 = x2, 10 = x4, 11 = x4.
REQ-007 clr  input  1  synchronous count clear and error clear.
REQ-008 count  output  CNT_W  signed two's-complement position.
REQ-009 pulse  output  1  one-cycle strobe per counted step.
REQ-010 dir  output  1  direction of last counted step: 1 = forward, 0 = reverse.
REQ-011 err  output  1  sticky illegal-transition flag.
REQ-012 ovf  output  1  one-cycle strobe on counter wrap.

Function
REQ-013 A and B each pass through a 2-flop synchroniser.
REQ-014 Filter: a new synchronised {A,B} value replaces the filtered value only after FILT_LEN consecutive identical samples that differ from it; shorter glitches are discarded.
REQ-015 Decoder state machine has two states, INIT and TRACK.
REQ-016 INIT: the first filtered value after reset loads the previous-phase register; no count and no err; go to TRACK.
REQ-017 TRACK forward sequence {A,B}: 00->10->11->01->00; reverse is the opposite order.
REQ-018 One-bit change = legal step; two-bit change = illegal: err set, count unchanged, no pulse, and the previous-phase register takes the new value.
REQ-019 x4 mode counts every legal step.
REQ-020 x2 mode counts only legal steps where A changes.
REQ-021 x1 mode counts only 00->10 (forward, +1) and 10->00 (reverse, -1).
REQ-022 Every counted step: count +/-1, pulse high for exactly one cycle, dir updated in the same cycle; uncounted legal steps leave pulse, dir and count unchanged.
REQ-023 Latency: a stable input change reaches count/pulse FILT_LEN+3 clk edges after the first edge that samples it.
REQ-024 Count wraps modulo 2^CNT_W: max->min on +1 and min->max on -1; ovf pulses in the wrap cycle.
REQ-025 mode changes take effect on the next step; count is not altered.
REQ-026 clr: count <= 0 and err <= 0 at the next edge.
REQ-027 clr coincident with a counted step: count = 0, pulse and dir still reflect the step, ovf = 0.
REQ-028 clr coincident with an illegal step: err stays 1.

Reset
REQ-029 While rst = 0 at a clk edge: count = 0, pulse = 0, dir = 0, err = 0, ovf = 0, synchronisers and filter cleared, state = INIT.
REQ-030 Reset mid-step discards any partially filtered value; after release the decoder re-enters INIT and counts nothing for the first accepted level.

Configuration
REQ-031 Macro QUAD_INDEX_EN defined: adds input Z (1 bit) and output idx (1 bit).
REQ-032 With QUAD_INDEX_EN, Z is 2-flop synchronised. A rising Z edge while the filtered phase = 00 sets count to 0 and pulses idx for one cycle.
REQ-033 With QUAD_INDEX_EN, clr has priority over the index clear; an index clear coincident with a counted step gives count = 0 with pulse still asserted.
REQ-034 QUAD_INDEX_EN undefined: Z and idx ports are absent; behaviour is otherwise identical.

Verification
REQ-035 CNT_W=16, FILT_LEN=3, x4, 10 full forward cycles (40 steps) -> count = 40, 40 single-cycle pulses, dir = 1; 4 reverse steps -> count = 36, dir = 0.
REQ-036 x1, then x2, then x4, each with one forward cycle -> count increments of 1, 2 and 4 respectively.
REQ-037 A glitch 2 cycles wide with FILT_LEN=3 -> no pulse and no count change; the same pulse held 3 cycles -> one step, pulse FILT_LEN+3 edges after the first sampling edge.
REQ-038 Phase 00->11 jump -> err = 1, count unchanged; clr pulse -> err = 0, count = 0.
REQ-039 CNT_W=4, count = 7, one forward step -> count = -8, ovf one cycle; one reverse step -> count = 7, ovf one cycle.
REQ-040 rst low during a forward sequence -> all outputs 0; after release the first accepted level = 10 -> no count; then 10->11 -> count = 1.
